// File: rtl/skid.sv
`default_nettype none
// ============================================================================
// Module   : skid
// Purpose  : Two-entry, fully registered valid/ready skid buffer. Cuts the
//            combinational path on both ready and data/valid while sustaining
//            one transfer per clock.
// Revision : 1.0 - initial release
// ============================================================================
module skid #(
  parameter int WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q,  in_ready_d;

  logic w_in_xfer;
  logic w_out_free;

  // An upstream word is taken only when the registered ready is high.
  assign w_in_xfer  = i_in_valid & in_ready_q;
  // The output register can be overwritten when empty or being drained now.
  assign w_out_free = ~out_valid_q | i_out_ready;

  // Next-state: refill the output register (skid first to keep FIFO order),
  // otherwise park an incoming word in the skid while the output is stalled.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (w_out_free) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (w_in_xfer) begin
        out_data_d  = i_in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_in_xfer) begin
      skid_data_d  = i_in_data;
      skid_valid_d = 1'b1;
    end
    // Ready is registered: it reflects whether the skid will be free.
    in_ready_d = ~skid_valid_d;
  end

  // State registers with synchronous reset that discards any held words.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign o_out_data  = out_data_q;
  assign o_out_valid = out_valid_q;
  assign o_in_ready  = in_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_skid
// Purpose  : Self-checking bench for skid. A queue of held words (capacity 2)
//            predicts valid, data and ready after every edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skid;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [15:0] i_in_data;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [15:0] o_out_data;
  logic        o_out_valid;
  logic        i_out_ready;

  skid #(.WIDTH(16)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_in_data   (i_in_data),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready)
  );

  always #5 i_clock = ~i_clock;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [15:0] model_q[$];  // words held by the buffer, head = presented word
  logic [15:0] sent_q[$];   // words the model accepted in the current phase
  logic [15:0] dut_out[$];  // words the DUT delivered in the current phase
  int unsigned acc_cnt;     // accepts observed on the DUT in the current phase
  logic        m_acc;
  int unsigned k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    dut_out.delete();
    sent_q.delete();
    acc_cnt = 0;
  endtask

  // One clock: drive inputs, observe the DUT handshake just before the edge,
  // advance the model, then check outputs 1 time unit after the edge.
  task automatic step(input logic rst, input logic v, input logic [15:0] d, input logic r);
    logic obs_out, obs_acc;
    logic [15:0] obs_data;
    i_reset     = rst;
    i_in_valid  = v;
    i_in_data   = d;
    i_out_ready = r;
    #1;
    obs_out  = o_out_valid & r;
    obs_acc  = o_in_ready & v;
    obs_data = o_out_data;
    @(posedge i_clock);
    if (!rst) begin
      if (obs_out) dut_out.push_back(obs_data);
      if (obs_acc) acc_cnt++;
    end
    if (rst) begin
      model_q.delete();
      m_acc = 1'b0;
    end else begin
      m_acc = v && (model_q.size() < 2);
      if (model_q.size() > 0 && r) void'(model_q.pop_front());
      if (m_acc) begin
        model_q.push_back(d);
        sent_q.push_back(d);
      end
    end
    #1;
    chk("out_valid", 32'(o_out_valid), 32'(model_q.size() > 0));
    chk("in_ready", 32'(o_in_ready), 32'(model_q.size() < 2));
    if (model_q.size() > 0) chk("out_data", 32'(o_out_data), 32'(model_q[0]));
    if (rst) chk("reset_data", 32'(o_out_data), 32'd0);
  endtask

  // Run n cycles with constant valid/ready; producer advances by stride on accept.
  task automatic burst(input int n, input logic v, input logic r, input int stride);
    for (int i = 0; i < n; i++) begin
      step(1'b0, v, v ? 16'(stride * k) : 16'($urandom), r);
      if (m_acc) k++;
    end
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h1234, 1'b1);

    // No input for 100 cycles, stale data on the bus
    clear_log();
    k = 0;
    burst(100, 1'b0, 1'b0, 1);
    chk("idle_xfers", dut_out.size(), 0);

    // Stall fill: only two words fit, head holds at 0
    step(1'b1, 1'b0, 16'h0, 1'b0);
    clear_log();
    k = 0;
    burst(100, 1'b1, 1'b0, 2);
    chk("stall_accepts", acc_cnt, 2);
    chk("stall_ready", 32'(o_in_ready), 32'd0);
    chk("stall_head", 32'(o_out_data), 32'd0);
    burst(10, 1'b0, 1'b1, 2);
    chk("stall_xfers", dut_out.size(), 2);
    for (int i = 0; i < dut_out.size() && i < 2; i++)
      chk("stall_val", 32'(dut_out[i]), 32'(2 * i));

    // Bursty ready: 2, 4, 10 cycle pulses with low gaps
    step(1'b1, 1'b0, 16'h0, 1'b0);
    clear_log();
    k = 0;
    burst(5, 1'b1, 1'b0, 3);
    burst(2, 1'b1, 1'b1, 3);
    burst(4, 1'b1, 1'b0, 3);
    burst(4, 1'b1, 1'b1, 3);
    burst(3, 1'b1, 1'b0, 3);
    burst(10, 1'b1, 1'b1, 3);
    burst(5, 1'b1, 1'b0, 3);
    chk("bready_xfers", dut_out.size(), 16);
    for (int i = 0; i < dut_out.size(); i++)
      chk("bready_val", 32'(dut_out[i]), 32'(3 * i));

    // Bursty valid: 5, 5, 35 cycle bursts with downstream always ready
    step(1'b1, 1'b0, 16'h0, 1'b0);
    clear_log();
    k = 0;
    burst(5, 1'b1, 1'b1, 4);
    burst(3, 1'b0, 1'b1, 4);
    burst(5, 1'b1, 1'b1, 4);
    burst(4, 1'b0, 1'b1, 4);
    burst(35, 1'b1, 1'b1, 4);
    burst(4, 1'b0, 1'b1, 4);
    chk("bvalid_xfers", dut_out.size(), 45);
    chk("bvalid_accepts", acc_cnt, 45);
    for (int i = 0; i < dut_out.size(); i++)
      chk("bvalid_val", 32'(dut_out[i]), 32'(4 * i));

    // Reset with both registers full discards the held words
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'hAAAA, 1'b0);
    step(1'b0, 1'b1, 16'hBBBB, 1'b0);
    chk("full_ready", 32'(o_in_ready), 32'd0);
    step(1'b1, 1'b1, 16'hCCCC, 1'b1);
    clear_log();
    k = 0;
    burst(6, 1'b0, 1'b1, 1);
    chk("post_reset_xfers", dut_out.size(), 0);

    // Random valid/ready with varying duty cycles
    step(1'b1, 1'b0, 16'h0, 1'b0);
    clear_log();
    for (int i = 0; i < 10000; i++) begin
      int unsigned vd, rd;
      vd = (i / 2500) + 1;
      rd = 4 - (i / 2500);
      step(1'b0, $urandom_range(0, 4) < vd, 16'($urandom),
           $urandom_range(0, 4) < rd);
    end
    burst(4, 1'b0, 1'b1, 1);
    chk("rand_count", dut_out.size(), sent_q.size());
    for (int i = 0; i < dut_out.size() && i < sent_q.size(); i++)
      chk("rand_order", 32'(dut_out[i]), 32'(sent_q[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
